// File: rtl/lsu_mem_bridge.sv
// Load-store unit bridging core byte/half/word accesses onto an aligned word memory port.
// Stalls the core until the memory responds, then extends the load data or times out.
module lsu_mem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  size_q, size_d;
    logic        we_q, we_d;

    logic        legal;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    logic [31:0] load_data;

    logic [31:0] rd;
    logic        stall;
    logic        err;
    logic        req;
    logic        we;

    always_comb begin
        legal = 1'b0;
        case (core_size_i)
            3'd0, 3'd4: legal = 1'b1;
            3'd1, 3'd5: legal = ~core_addr_i[0];
            3'd2:       legal = (core_addr_i[1:0] == 2'b00);
            default:    legal = 1'b0;
        endcase
    end

    // Sizes 4/5 share lane handling with 0/1, so the low two size bits pick the lane shape.
    always_comb begin
        be = 4'b1111;
        wd = core_wd_i;
        case (core_size_i[1:0])
            2'd0: begin
                be = 4'b0001 << core_addr_i[1:0];
                wd = {4{core_wd_i[7:0]}};
            end
            2'd1: begin
                be = core_addr_i[1] ? 4'b1100 : 4'b0011;
                wd = {2{core_wd_i[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = core_wd_i;
            end
        endcase
    end

    always_comb begin
        byte_sh   = mem_rd_i >> {off_q, 3'b000};
        half_sh   = mem_rd_i >> {off_q[1], 4'b0000};
        load_data = mem_rd_i;
        case (size_q)
            3'd0:    load_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'd1:    load_data = {{16{half_sh[15]}}, half_sh[15:0]};
            3'd4:    load_data = {24'd0, byte_sh[7:0]};
            3'd5:    load_data = {16'd0, half_sh[15:0]};
            default: load_data = mem_rd_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        size_d  = size_q;
        we_d    = we_q;
        rd      = '0;
        stall   = 1'b0;
        err     = 1'b0;
        req     = 1'b0;
        we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (core_req_i) begin
                    if (legal) begin
                        req     = 1'b1;
                        we      = core_we_i;
                        stall   = 1'b1;
                        off_d   = core_addr_i[1:0];
                        size_d  = core_size_i;
                        we_d    = core_we_i;
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // A response arriving on the last allowed cycle takes priority over the timeout.
                if (mem_ready_i) begin
                    rd      = we_q ? '0 : load_data;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            size_q  <= size_d;
            we_q    <= we_d;
        end
    end

    assign core_rd_o    = rst_ni ? rd : '0;
    assign core_stall_o = rst_ni & stall;
    assign core_err_o   = rst_ni & err;
    assign mem_req_o    = rst_ni & req;
    assign mem_we_o     = rst_ni & we;
    assign mem_be_o     = (rst_ni & req) ? be : '0;
    assign mem_wd_o     = (rst_ni & req) ? wd : '0;
    assign mem_addr_o   = rst_ni ? {core_addr_i[31:2], 2'b00} : '0;

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed bench for lsu_mem_bridge with TIMEOUT_CYCLES=4; memory responses are driven by hand.
module tb_lsu_mem_bridge;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    int checks = 0;
    int errors = 0;

    lsu_mem_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .core_err_o   (core_err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic req, input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdat);
        core_req_i  = req;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wdat;
    endtask

    task automatic mem(input logic rdy, input logic [31:0] rdat);
        mem_ready_i = rdy;
        mem_rd_i    = rdat;
    endtask

    initial begin
        rst_ni = 1'b0;
        drive(1'b1, 1'b1, 3'd2, 32'h0000_0010, 32'hFFFF_FFFF);
        mem(1'b1, 32'hFFFF_FFFF);
        #3;
        chk("rst_req",   {31'd0, mem_req_o},    32'd0);
        chk("rst_stall", {31'd0, core_stall_o}, 32'd0);
        chk("rst_err",   {31'd0, core_err_o},   32'd0);
        chk("rst_rd",    core_rd_o,             32'd0);
        chk("rst_addr",  mem_addr_o,            32'd0);
        chk("rst_wd",    mem_wd_o,              32'd0);
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        mem(1'b0, 32'd0);
        cyc();
        rst_ni = 1'b1;
        cyc();

        // 1: LB / LBU at offset 3 of 0xFA111EAF
        drive(1'b1, 1'b0, 3'd0, 32'h0000_0003, 32'd0);
        @(negedge clk_i);
        chk("lb_issue_req",   {31'd0, mem_req_o},    32'd1);
        chk("lb_issue_be",    {28'd0, mem_be_o},     32'h8);
        chk("lb_issue_stall", {31'd0, core_stall_o}, 32'd1);
        chk("lb_issue_addr",  mem_addr_o,            32'h0);
        cyc();
        mem(1'b1, 32'hFA11_1EAF);
        @(negedge clk_i);
        chk("lb_rel_stall", {31'd0, core_stall_o}, 32'd0);
        chk("lb_rel_req",   {31'd0, mem_req_o},    32'd0);
        chk("lb_rel_rd",    core_rd_o,             32'hFFFF_FFFA);
        cyc();
        mem(1'b0, 32'd0);
        drive(1'b1, 1'b0, 3'd4, 32'h0000_0003, 32'd0);
        @(negedge clk_i);
        chk("lbu_issue_be", {28'd0, mem_be_o}, 32'h8);
        chk("lbu_idle_rd",  core_rd_o,         32'd0);
        cyc();
        mem(1'b1, 32'hFA11_1EAF);
        @(negedge clk_i);
        chk("lbu_rel_rd", core_rd_o, 32'h0000_00FA);
        cyc();

        // 2: SH at 0x6 with replicated data; ready immediately after issue
        mem(1'b0, 32'd0);
        drive(1'b1, 1'b1, 3'd1, 32'h0000_0006, 32'h1234_BEEF);
        @(negedge clk_i);
        chk("sh_addr",  mem_addr_o,            32'h4);
        chk("sh_be",    {28'd0, mem_be_o},     32'hC);
        chk("sh_wd",    mem_wd_o,              32'hBEEF_BEEF);
        chk("sh_we",    {31'd0, mem_we_o},     32'd1);
        chk("sh_stall", {31'd0, core_stall_o}, 32'd1);
        cyc();
        mem(1'b1, 32'h5555_5555);
        @(negedge clk_i);
        chk("sh_wait_we",    {31'd0, mem_we_o},     32'd0);
        chk("sh_wait_req",   {31'd0, mem_req_o},    32'd0);
        chk("sh_rel_stall",  {31'd0, core_stall_o}, 32'd0);
        chk("sh_rel_rd",     core_rd_o,             32'd0);
        cyc();
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk_i);
        chk("idle_ready_ignored_stall", {31'd0, core_stall_o}, 32'd0);
        chk("idle_ready_ignored_rd",    core_rd_o,             32'd0);
        cyc();
        mem(1'b0, 32'd0);

        // 3: misaligned word and illegal size
        drive(1'b1, 1'b0, 3'd2, 32'h0000_0005, 32'd0);
        @(negedge clk_i);
        chk("lw_mis_req",   {31'd0, mem_req_o},    32'd0);
        chk("lw_mis_err",   {31'd0, core_err_o},   32'd1);
        chk("lw_mis_stall", {31'd0, core_stall_o}, 32'd0);
        cyc();
        drive(1'b1, 1'b0, 3'd3, 32'h0000_0000, 32'd0);
        @(negedge clk_i);
        chk("sz3_req", {31'd0, mem_req_o},  32'd0);
        chk("sz3_err", {31'd0, core_err_o}, 32'd1);
        cyc();
        drive(1'b1, 1'b0, 3'd1, 32'h0000_0001, 32'd0);
        @(negedge clk_i);
        chk("lh_mis_err", {31'd0, core_err_o}, 32'd1);
        cyc();
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk_i);
        chk("err_clear", {31'd0, core_err_o}, 32'd0);
        cyc();

        // 4: timeout after issue + 3 WAIT cycles
        drive(1'b1, 1'b0, 3'd2, 32'h0000_0000, 32'd0);
        @(negedge clk_i);
        chk("to_issue_stall", {31'd0, core_stall_o}, 32'd1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("to_wait_stall", {31'd0, core_stall_o}, 32'd1);
            chk("to_wait_err",   {31'd0, core_err_o},   32'd0);
            cyc();
        end
        @(negedge clk_i);
        chk("to_rel_stall", {31'd0, core_stall_o}, 32'd0);
        chk("to_rel_err",   {31'd0, core_err_o},   32'd1);
        chk("to_rel_rd",    core_rd_o,             32'd0);
        cyc();
        @(negedge clk_i);
        chk("to_next_issue", {31'd0, mem_req_o}, 32'd1);
        chk("to_next_err",   {31'd0, core_err_o}, 32'd0);
        cyc();
        mem(1'b1, 32'hFA11_1EAF);
        @(negedge clk_i);
        chk("to_next_rd", core_rd_o, 32'hFA11_1EAF);
        cyc();

        // ready on the final allowed WAIT cycle wins over timeout
        mem(1'b0, 32'd0);
        drive(1'b1, 1'b0, 3'd2, 32'h0000_0000, 32'd0);
        cyc();
        cyc();
        cyc();
        cyc();
        mem(1'b1, 32'h0BAD_F00D);
        @(negedge clk_i);
        chk("race_err", {31'd0, core_err_o}, 32'd0);
        chk("race_rd",  core_rd_o,           32'h0BAD_F00D);
        cyc();

        // 5: back-to-back SW then LW at 0x8
        mem(1'b0, 32'd0);
        drive(1'b1, 1'b1, 3'd2, 32'h0000_0008, 32'hDEAD_BEEF);
        @(negedge clk_i);
        chk("sw_be",   {28'd0, mem_be_o}, 32'hF);
        chk("sw_wd",   mem_wd_o,          32'hDEAD_BEEF);
        chk("sw_addr", mem_addr_o,        32'h8);
        cyc();
        mem(1'b1, 32'd0);
        @(negedge clk_i);
        chk("sw_rel_stall", {31'd0, core_stall_o}, 32'd0);
        cyc();
        mem(1'b0, 32'd0);
        drive(1'b1, 1'b0, 3'd2, 32'h0000_0008, 32'd0);
        @(negedge clk_i);
        chk("lw_b2b_req", {31'd0, mem_req_o}, 32'd1);
        chk("lw_b2b_we",  {31'd0, mem_we_o},  32'd0);
        cyc();
        mem(1'b1, 32'hDEAD_BEEF);
        @(negedge clk_i);
        chk("lw_b2b_rd", core_rd_o, 32'hDEAD_BEEF);
        cyc();

        // 6: asynchronous reset in WAIT, then LHU at 0x2
        mem(1'b0, 32'd0);
        drive(1'b1, 1'b0, 3'd2, 32'h0000_0000, 32'd0);
        cyc();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_stall", {31'd0, core_stall_o}, 32'd0);
        chk("arst_err",   {31'd0, core_err_o},   32'd0);
        chk("arst_req",   {31'd0, mem_req_o},    32'd0);
        chk("arst_rd",    core_rd_o,             32'd0);
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        cyc();
        rst_ni = 1'b1;
        mem(1'b1, 32'h1234_5678);
        @(negedge clk_i);
        chk("post_rst_idle_stall", {31'd0, core_stall_o}, 32'd0);
        chk("post_rst_idle_err",   {31'd0, core_err_o},   32'd0);
        chk("post_rst_idle_rd",    core_rd_o,             32'd0);
        cyc();
        mem(1'b0, 32'd0);
        drive(1'b1, 1'b0, 3'd5, 32'h0000_0002, 32'd0);
        @(negedge clk_i);
        chk("lhu_be", {28'd0, mem_be_o}, 32'hC);
        cyc();
        mem(1'b1, 32'h8001_7FFF);
        @(negedge clk_i);
        chk("lhu_rd", core_rd_o, 32'h0000_8001);
        cyc();
        mem(1'b0, 32'd0);
        drive(1'b1, 1'b0, 3'd1, 32'h0000_0002, 32'd0);
        cyc();
        mem(1'b1, 32'h8001_7FFF);
        @(negedge clk_i);
        chk("lh_rd", core_rd_o, 32'hFFFF_8001);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
